// File: rtl/wallace_acc_if.sv
// wallace_acc_if: product-in / frame-result-out handshake bundle for wallace_acc.
interface wallace_acc_if #(parameter int ACC_W = 24) ();
  logic             clear;
  logic [15:0]      prod_i;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic [7:0]       term_cnt;
  logic             ovf;
  modport master (output clear, prod_i, prod_valid, acc_ready,
                  input  prod_ready, acc_out, acc_valid, term_cnt, ovf);
  modport slave  (input  clear, prod_i, prod_valid, acc_ready,
                  output prod_ready, acc_out, acc_valid, term_cnt, ovf);
endinterface

// File: rtl/wallace_acc.sv
// wallace_acc: sums LEN consecutive 16-bit products into one frame result.
// Define WALLACE_ACC_SAT_EN to saturate on overflow instead of wrapping.
module wallace_acc #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  wallace_acc_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d, acc_new;
  logic [ACC_W:0]   sum;
  logic [7:0]       term_q, term_d;
  logic             ovf_q, ovf_d, accept, last, carry;
  always_comb begin
    accept    = bus.prod_valid && state_q == ACCUM;
    sum       = (ACC_W+1)'(acc_q) + (ACC_W+1)'(bus.prod_i);
    carry     = sum[ACC_W];
`ifdef WALLACE_ACC_SAT_EN
    acc_new   = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_new   = sum[ACC_W-1:0];
`endif
    last      = term_q == 8'(LEN - 1);
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    term_d    = term_q;
    ovf_d     = ovf_q;
    if (bus.clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      term_d  = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      ovf_d     = ovf_q | carry;
      acc_d     = last ? '0 : acc_new;
      term_d    = last ? '0 : term_q + 8'd1;
      acc_out_d = last ? acc_new : acc_out_q;
      state_d   = last ? HOLD : ACCUM;
    end else if (state_q == HOLD && bus.acc_ready) begin
      state_d = ACCUM;
      ovf_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      acc_out_q <= '0;
      term_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      term_q    <= term_d;
      ovf_q     <= ovf_d;
    end
  end
  assign bus.prod_ready = state_q == ACCUM;
  assign bus.acc_valid  = state_q == HOLD;
  assign bus.acc_out    = acc_out_q;
  assign bus.term_cnt   = term_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_wallace_acc.sv
// tb_wallace_acc: directed vectors for wallace_acc (24b/LEN 8 and 16b/LEN 2 instances).
module tb_wallace_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] ovf_exp;
  int   cnt;
  always #5 clk = ~clk;
  wallace_acc_if #(.ACC_W(24)) a ();
  wallace_acc_if #(.ACC_W(16)) b ();
  wallace_acc #(.ACC_W(24), .LEN(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  wallace_acc #(.ACC_W(16), .LEN(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] p);
    a.prod_valid = 1'b1;
    a.prod_i     = p;
    step();
  endtask
  initial begin
`ifdef WALLACE_ACC_SAT_EN
    ovf_exp = 16'hFFFF;
`else
    ovf_exp = 16'h0001;
`endif
    {a.clear, a.prod_i, a.prod_valid, a.acc_ready} = '0;
    {b.clear, b.prod_i, b.prod_valid, b.acc_ready} = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_valid", a.acc_valid, 0);
    chk("rst_ready", a.prod_ready, 1);
    chk("rst_term", a.term_cnt, 0);
    chk("rst_ovf", a.ovf, 0);
    chk("rst_out", a.acc_out, 0);
    a.acc_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("basic_ready", a.prod_ready, 1);
      send(16'(16'h70 * k));
    end
    a.prod_valid = 1'b0;
    chk("basic_valid", a.acc_valid, 1);
    chk("basic_out", a.acc_out, 32'h000FC0);
    chk("basic_bubble", a.prod_ready, 0);
    chk("basic_term0", a.term_cnt, 0);
    step();
    chk("basic_valid1cyc", a.acc_valid, 0);
    chk("basic_ready_back", a.prod_ready, 1);
    for (int k = 0; k < 3; k++) send(16'h0123);
    a.prod_valid = 1'b0;
    chk("pre_rst_term", a.term_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_term", a.term_cnt, 0);
    chk("async_out", a.acc_out, 0);
    chk("async_ready", a.prod_ready, 1);
    chk("async_valid", a.acc_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    a.acc_ready = 1'b0;
    for (int k = 1; k <= 8; k++) send(16'(16'h70 * k));
    a.prod_i = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out", a.acc_out, 32'h000FC0);
      chk("bp_ready", a.prod_ready, 0);
      chk("bp_term", a.term_cnt, 0);
      step();
    end
    a.acc_ready = 1'b1;
    step();
    chk("bp_handoff_valid", a.acc_valid, 0);
    chk("bp_not_accepted", a.term_cnt, 0);
    for (int k = 0; k < 8; k++) send(16'h0100);
    a.prod_valid = 1'b0;
    chk("bp_frame2", a.acc_out, 32'h000800);
    step();
    cnt = 0;
    for (int i = 0; i < 22; i++) begin
      a.prod_valid = (i % 3) == 0;
      a.prod_i = 16'h0001;
      step();
      if (i % 3 == 0) cnt++;
      if (cnt < 8) chk("gap_term", a.term_cnt, 32'(cnt));
    end
    a.prod_valid = 1'b0;
    chk("gap_valid", a.acc_valid, 1);
    chk("gap_out", a.acc_out, 8);
    step();
    for (int k = 0; k < 4; k++) send(16'h0055);
    a.clear = 1'b1;
    send(16'h0055);
    a.clear = 1'b0;
    a.prod_valid = 1'b0;
    chk("clr_term", a.term_cnt, 0);
    chk("clr_ready", a.prod_ready, 1);
    for (int k = 0; k < 8; k++) send(16'h0010);
    a.prod_valid = 1'b0;
    chk("clr_frame", a.acc_out, 32'h000080);
    a.acc_ready = 1'b0;
    step();
    a.clear = 1'b1;
    step();
    a.clear = 1'b0;
    chk("clr_hold_valid", a.acc_valid, 0);
    chk("clr_hold_ready", a.prod_ready, 1);
    b.prod_valid = 1'b1;
    b.prod_i = 16'hFFFF;
    step();
    chk("ovf_first", b.ovf, 0);
    chk("ovf_term1", b.term_cnt, 1);
    b.prod_i = 16'h0002;
    step();
    b.prod_valid = 1'b0;
    chk("ovf_valid", b.acc_valid, 1);
    chk("ovf_out", b.acc_out, 32'(ovf_exp));
    chk("ovf_set", b.ovf, 1);
    step();
    chk("ovf_hold", b.ovf, 1);
    chk("ovf_hold_out", b.acc_out, 32'(ovf_exp));
    b.acc_ready = 1'b1;
    step();
    chk("ovf_cleared", b.ovf, 0);
    chk("ovf_handoff", b.acc_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wallace_acc.md
# wallace_acc

Downstream accumulation stage for `wallace_multiplier`. Consumes the unsigned 16-bit product stream and sums a fixed number of consecutive products (LEN) into one frame result. Presents each result on a valid/ready output port. Together with the multiplier it forms the datapath's dot-product (MAC) unit.

## Interface
Parameters:
- `ACC_W`, 24: accumulator and result width; legal range is ACC_W >= 16.
- `LEN`, 8: products per frame; legal range is 2..255.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `clear`, input, 1: synchronous abort of the current frame.
- `prod_i`, input, 16: product from `wallace_multiplier`.
- `prod_valid`, input, 1: `prod_i` is valid this cycle.
- `prod_ready`, output, 1: block accepts `prod_i` this cycle.
- `acc_out`, output, ACC_W: registered frame result.
- `acc_valid`, output, 1: `acc_out` holds a complete frame.
- `acc_ready`, input, 1: consumer accepts `acc_out`.
- `term_cnt`, output, 8: products accepted in the current frame.
- `ovf`, output, 1: sticky flag; the current or held frame exceeded ACC_W.

## Operation
- Two states:
  - ACCUM: `prod_ready`=1.
  - HOLD: `prod_ready`=0, `acc_valid`=1.
- A product is accepted when `prod_valid & prod_ready`.
  - `prod_i` is zero-extended to ACC_W and added to the internal accumulator.
  - `term_cnt` increments.
- When the accepted product is term LEN (that is, `term_cnt`==LEN-1 before the accept):
  - `acc_out` is loaded with the final sum.
  - The internal accumulator and `term_cnt` are zeroed.
  - The state goes to HOLD.
- HOLD plus `acc_ready`=1 → ACCUM on the next cycle and `ovf` clears. `acc_out` keeps its last value but is meaningless while `acc_valid`=0.
- `ovf` sets when the ACC_W-bit addition produces a carry-out. It stays set until the frame handoff, `clear`, or reset.
- `clear`=1 has priority over all other inputs:
  - Next cycle: state ACCUM, accumulator 0, `term_cnt` 0, `ovf` 0, `acc_valid` 0.
  - A product offered in the same cycle is dropped.
  - An unconsumed HOLD result is discarded.
- `prod_valid` while `prod_ready`=0 has no effect. The upstream multiplier must hold or retry.

## Timing
- Reset values:
  - state ACCUM, so `prod_ready`=1.
  - `acc_out`=0, `acc_valid`=0, `term_cnt`=0, `ovf`=0.
  - Reset asserted mid-frame discards all partial state immediately, with no clock required.
- Latency: `acc_valid` rises in the cycle after the LEN-th accept.
- `acc_out`, `acc_valid` and `ovf` are register outputs. `prod_ready` decodes state only and never depends combinationally on `prod_valid` or `acc_ready`.
- While `acc_valid`=1 and `acc_ready`=0, `acc_out` and `ovf` are held stable.
- The handoff cycle is a bubble: `prod_ready` is 0 in it and is 1 from the following cycle.
- Maximum throughput is one frame per LEN+1 cycles.
- `acc_ready` asserted while in ACCUM is ignored.

## Configuration
Macro `WALLACE_ACC_SAT_EN`:
- Defined: on carry-out, the accumulator saturates at 2^ACC_W-1 and `ovf` sets. Later adds keep it saturated.
- Undefined: the accumulator wraps modulo 2^ACC_W and `ovf` still sets on carry-out.
- Frame sequencing, handshakes and the bubble are identical in both builds.

## Test plan
- Reset then idle: `acc_valid`=0, `prod_ready`=1, `term_cnt`=0, `ovf`=0. Pulse `rst_n` low mid-frame after 3 accepts: all outputs return to reset values asynchronously.
- Basic frame (LEN=8, `acc_ready`=1): stream products 0x70·k for k=1..8 (0x0070, 0x00E0, …, 0x0380), one per cycle. Required:
  - `acc_out`=0x000FC0, `acc_valid` high for 1 cycle starting the cycle after the 8th accept.
  - `prod_ready`=0 for exactly 1 cycle.
- Backpressure: same frame with `acc_ready`=0 for 5 cycles. Required:
  - `acc_out`=0x000FC0 stable and `prod_ready`=0 throughout.
  - Held `prod_valid` products are not accepted.
  - The second frame sums correctly after `acc_ready` rises.
- Gapped input: `prod_valid` toggles 1,0,0,1,…, 8 products of 0x0001. Required: `acc_out`=8 and `term_cnt` counts only accepted cycles.
- Overflow (ACC_W=16, LEN=2): products 0xFFFF then 0x0002. Required:
  - Without the macro: `acc_out`=0x0001, `ovf`=1.
  - With `WALLACE_ACC_SAT_EN`: `acc_out`=0xFFFF, `ovf`=1.
  - `ovf` clears after the handoff.
- Clear: assert `clear` after 4 accepts, simultaneous with `prod_valid`. Then run a full frame of 0x0010. Required:
  - Next cycle `term_cnt`=0.
  - Frame result is 0x000080 (LEN=8), with no contribution from the aborted frame.
